// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } mem_state_t;

    typedef logic [3:0] byte_en_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // True when funct3 is a legal size for this access and the address suits that size.
    // Store encodings share values with LB/LH/LW, so only the load names appear here.
    function automatic logic accessOk(input logic isLoad, input logic [2:0] f3,
                                      input logic [1:0] byteOff);
        logic ok;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = !byteOff[0];
            F3_LW:   ok = (byteOff == 2'b00);
            F3_LBU:  ok = isLoad;
            F3_LHU:  ok = isLoad && !byteOff[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// Byte-lane steering for stores and extract/extend for loads (purely combinational).
module lsu_lane_format
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic            isStore,
    input  logic [1:0]      byteOff,
    input  logic [XLEN-1:0] storeData,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output byte_en_t        byteEn,
    output logic [XLEN-1:0] loadData
);

    logic [XLEN-1:0] shifted;

    // Store: replicate narrow data to every lane, enable only the addressed lanes.
    always_comb begin
        wdata  = storeData;
        byteEn = 4'b1111;
        if (isStore) begin
            case (funct3[1:0])
                2'b00: begin
                    wdata  = {4{storeData[7:0]}};
                    byteEn = 4'b0001 << byteOff;
                end
                2'b01: begin
                    wdata  = {2{storeData[15:0]}};
                    byteEn = 4'b0011 << byteOff;
                end
                default: begin
                    wdata  = storeData;
                    byteEn = 4'b1111;
                end
            endcase
        end
    end

    // Load: bring the addressed byte/halfword down to bit 0, then extend.
    always_comb begin
        shifted = rdata >> {byteOff, 3'b000};
        case (funct3)
            F3_LB:   loadData = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   loadData = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  loadData = {24'd0, shifted[7:0]};
            F3_LHU:  loadData = {16'd0, shifted[15:0]};
            default: loadData = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives the data-memory req/gnt/rvalid bus, stalls the
// pipeline while an access is outstanding, and registers formatted load data for W.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            StallMem,
    output logic [XLEN-1:0] ReadDataW,
    output logic            MisalignW,
    output logic            BusErrW,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output byte_en_t        dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    mem_state_t      stateQ, stateD;
    logic [CntW-1:0] waitCntQ, waitCntD;
    logic            dropPendingQ, dropPendingD;

    logic            access;
    logic            aligned;
    logic            doAccess;
    logic            cntLast;
    logic            timeout;
    logic            complete;
    logic [XLEN-1:0] loadData;

    assign access   = MemReadM | MemWriteM;
    assign aligned  = accessOk(MemReadM, Funct3M, ALUResultM[1:0]);
    assign doAccess = access && aligned;
    assign cntLast  = (waitCntQ == CntW'(MAX_WAIT - 1));

    // Bus fields come straight from the M stage, which StallMem holds frozen.
    assign dmem_we   = MemWriteM;
    assign dmem_addr = {ALUResultM[XLEN-1:2], 2'b00};

    lsu_lane_format #(
        .XLEN(XLEN)
    ) u_lane_format (
        .funct3   (Funct3M),
        .isStore  (MemWriteM),
        .byteOff  (ALUResultM[1:0]),
        .storeData(WriteDataM),
        .rdata    (dmem_rdata),
        .wdata    (dmem_wdata),
        .byteEn   (dmem_be),
        .loadData (loadData)
    );

    // Next-state, request, stall and timeout decode.
    always_comb begin
        stateD       = stateQ;
        waitCntD     = '0;
        dropPendingD = dropPendingQ;
        dmem_req     = 1'b0;
        StallMem     = 1'b0;
        timeout      = 1'b0;
        complete     = 1'b0;
        case (stateQ)
            StIdle: begin
                // A response owed to an abandoned access is swallowed here.
                if (dropPendingQ && dmem_rvalid) begin
                    dropPendingD = 1'b0;
                end
                if (doAccess) begin
                    StallMem = 1'b1;
                    if (!dropPendingQ) begin
                        dmem_req = 1'b1;
                        stateD   = dmem_gnt ? StWait : StReq;
                    end
                end
            end
            StReq: begin
                dmem_req = 1'b1;
                StallMem = doAccess;
                waitCntD = waitCntQ + 1'b1;
                if (cntLast) begin
                    timeout      = 1'b1;
                    StallMem     = 1'b0;
                    stateD       = StIdle;
                    waitCntD     = '0;
                    // Granted in the final cycle: its response will still arrive.
                    dropPendingD = dmem_gnt;
                end else if (dmem_gnt) begin
                    stateD = StWait;
                end
            end
            StWait: begin
                StallMem = doAccess;
                waitCntD = waitCntQ + 1'b1;
                if (dmem_rvalid) begin
                    complete = 1'b1;
                    StallMem = 1'b0;
                    stateD   = StIdle;
                    waitCntD = '0;
                end else if (cntLast) begin
                    timeout      = 1'b1;
                    StallMem     = 1'b0;
                    stateD       = StIdle;
                    waitCntD     = '0;
                    dropPendingD = 1'b1;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // FSM, timeout counter and drop flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ       <= StIdle;
            waitCntQ     <= '0;
            dropPendingQ <= 1'b0;
        end else begin
            stateQ       <= stateD;
            waitCntQ     <= waitCntD;
            dropPendingQ <= dropPendingD;
        end
    end

    // W-stage results advance only when the pipeline advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            ReadDataW <= '0;
            MisalignW <= 1'b0;
            BusErrW   <= 1'b0;
        end else if (!StallMem) begin
            ReadDataW <= (complete && MemReadM) ? loadData : '0;
            MisalignW <= access && !aligned;
            BusErrW   <= timeout;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short timeout (MAX_WAIT = 4).
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallMem;
    logic [31:0] ReadDataW;
    logic        MisalignW;
    logic        BusErrW;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    byte_en_t    dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int testCnt = 0;
    int failCnt = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .XLEN    (32),
        .MAX_WAIT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallMem   (StallMem),
        .ReadDataW  (ReadDataW),
        .MisalignW  (MisalignW),
        .BusErrW    (BusErrW),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setAcc(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    task automatic idle();
        setAcc(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Grant now, respond next cycle, then retire the instruction.
    task automatic complete(input logic [31:0] rd);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rd;
        tick();
        dmem_rvalid = 1'b0;
        idle();
    endtask

    initial begin
        reset       = 1'b1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_readdata", ReadDataW, 32'h0);
        check("rst_misalign", MisalignW, 1'b0);
        check("rst_buserr", BusErrW, 1'b0);
        check("rst_stall", StallMem, 1'b0);
        check("rst_req", dmem_req, 1'b0);

        // SW 0x100 <- 0xDEADBEEF, granted at once, response two cycles later.
        setAcc(1'b0, 1'b1, F3_SW, 32'h100, 32'hDEADBEEF);
        dmem_gnt = 1'b1;
        #1;
        check("sw_req", dmem_req, 1'b1);
        check("sw_we", dmem_we, 1'b1);
        check("sw_be", dmem_be, 4'b1111);
        check("sw_addr", dmem_addr, 32'h100);
        check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        check("sw_stall0", StallMem, 1'b1);
        tick();
        dmem_gnt = 1'b0;
        #1;
        check("sw_req_wait", dmem_req, 1'b0);
        check("sw_stall1", StallMem, 1'b1);
        tick();
        dmem_rvalid = 1'b1;
        #1;
        check("sw_stall_done", StallMem, 1'b0);
        tick();
        dmem_rvalid = 1'b0;
        check("sw_readdata", ReadDataW, 32'h0);

        // LB 0x103 immediately after: byte 0x80 sign-extends.
        setAcc(1'b1, 1'b0, F3_LB, 32'h103, 32'h0);
        dmem_gnt = 1'b1;
        #1;
        check("lb_b2b_req", dmem_req, 1'b1);
        check("lb_stall", StallMem, 1'b1);
        check("lb_be", dmem_be, 4'b1111);
        check("lb_addr", dmem_addr, 32'h100);
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FF0000;
        #1;
        check("lb_stall_done", StallMem, 1'b0);
        tick();
        dmem_rvalid = 1'b0;
        check("lb_data", ReadDataW, 32'hFFFFFF80);

        setAcc(1'b1, 1'b0, F3_LBU, 32'h103, 32'h0);
        complete(32'h80FF0000);
        check("lbu_data", ReadDataW, 32'h00000080);

        // SH 0x102: halfword replicated, upper lanes enabled.
        setAcc(1'b0, 1'b1, F3_SH, 32'h102, 32'h0000ABCD);
        #1;
        check("sh_wdata", dmem_wdata, 32'hABCDABCD);
        check("sh_be", dmem_be, 4'b1100);
        check("sh_addr", dmem_addr, 32'h100);
        check("sh_req", dmem_req, 1'b1);
        complete(32'h0);

        // SB 0x101: byte replicated, lane 1.
        setAcc(1'b0, 1'b1, F3_SB, 32'h101, 32'h123456A5);
        #1;
        check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        check("sb_be", dmem_be, 4'b0010);
        complete(32'h0);

        // LH 0x002 with a late grant (passes through REQ).
        setAcc(1'b1, 1'b0, F3_LH, 32'h002, 32'h0);
        tick();
        #1;
        check("lh_req_held", dmem_req, 1'b1);
        check("lh_stall_req", StallMem, 1'b1);
        complete(32'h80011234);
        check("lh_data", ReadDataW, 32'hFFFF8001);

        setAcc(1'b1, 1'b0, F3_LHU, 32'h002, 32'h0);
        complete(32'h80011234);
        check("lhu_data", ReadDataW, 32'h00008001);

        setAcc(1'b1, 1'b0, F3_LW, 32'h104, 32'h0);
        complete(32'h13579BDF);
        check("lw_data", ReadDataW, 32'h13579BDF);

        // Misaligned LW 0x101: no request, no stall, one-cycle flag.
        setAcc(1'b1, 1'b0, F3_LW, 32'h101, 32'h0);
        #1;
        check("mis_req", dmem_req, 1'b0);
        check("mis_stall", StallMem, 1'b0);
        tick();
        idle();
        check("mis_flag", MisalignW, 1'b1);
        check("mis_readdata", ReadDataW, 32'h0);
        tick();
        check("mis_flag_clear", MisalignW, 1'b0);

        // Unsupported load size is treated as misaligned.
        setAcc(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
        #1;
        check("bad_f3_req", dmem_req, 1'b0);
        tick();
        idle();
        check("bad_f3_flag", MisalignW, 1'b1);

        // Misaligned SH: store suppressed.
        setAcc(1'b0, 1'b1, F3_SH, 32'h101, 32'h1);
        #1;
        check("mis_sh_req", dmem_req, 1'b0);
        tick();
        idle();
        tick();

        // Timeout: grant after two cycles, no response, abandon on the 4th stalled cycle.
        setAcc(1'b1, 1'b0, F3_LW, 32'h200, 32'h0);
        #1;
        check("to_req0", dmem_req, 1'b1);
        check("to_stall0", StallMem, 1'b1);
        tick();
        check("to_req1", dmem_req, 1'b1);
        check("to_addr1", dmem_addr, 32'h200);
        tick();
        dmem_gnt = 1'b1;
        #1;
        check("to_req2", dmem_req, 1'b1);
        check("to_stall2", StallMem, 1'b1);
        tick();
        dmem_gnt = 1'b0;
        #1;
        check("to_req3", dmem_req, 1'b0);
        check("to_stall3", StallMem, 1'b1);
        tick();
        check("to_release", StallMem, 1'b0);
        tick();
        check("to_buserr", BusErrW, 1'b1);
        check("to_readdata", ReadDataW, 32'h0);
        // Next load must wait for the stale response before requesting.
        setAcc(1'b1, 1'b0, F3_LW, 32'h300, 32'h0);
        #1;
        check("drop_req0", dmem_req, 1'b0);
        check("drop_stall0", StallMem, 1'b1);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEADDEAD;
        #1;
        check("drop_req1", dmem_req, 1'b0);
        check("drop_stall1", StallMem, 1'b1);
        tick();
        dmem_rvalid = 1'b0;
        #1;
        check("drop_req2", dmem_req, 1'b1);
        check("drop_addr2", dmem_addr, 32'h300);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        #1;
        check("drop_stall_done", StallMem, 1'b0);
        tick();
        dmem_rvalid = 1'b0;
        idle();
        check("drop_data", ReadDataW, 32'h12345678);
        check("drop_buserr_clear", BusErrW, 1'b0);

        // Reset while waiting for a response.
        setAcc(1'b1, 1'b0, F3_LW, 32'h400, 32'h0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        reset    = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        #1;
        check("rstw_req", dmem_req, 1'b0);
        check("rstw_stall", StallMem, 1'b0);
        check("rstw_readdata", ReadDataW, 32'h0);
        check("rstw_misalign", MisalignW, 1'b0);
        check("rstw_buserr", BusErrW, 1'b0);
        setAcc(1'b1, 1'b0, F3_LW, 32'h400, 32'h0);
        #1;
        check("rstw_idle_req", dmem_req, 1'b1);
        complete(32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
